// File: rtl/apb_reg_slave.sv
// APB slave register file: NUM_REGS 8-bit read/write registers behind an APB3-style slave port.
// Latency: setup cycle + WAIT_STATES wait cycles + 1 access cycle with pready=1; pready/prdata/pslverr are registered.
// Backpressure: holds pready low for WAIT_STATES access cycles; dropping psel mid-transfer aborts back to IDLE.
//
// Ports:
//   pclk, presetn                 clock, asynchronous active-low reset
//   psel, penable, pwrite         APB control from the master
//   paddr[7:0]                    address, sampled in the setup phase only
//   pwdata[7:0]                   write data, sampled on the completing edge
//   pready                        transfer completes in this cycle
//   prdata[7:0]                   read data, held until the next READY entry
//   pslverr                       out-of-range error, present only with APB_SLAVE_PSLVERR_EN
//
// Optional feature macro: APB_SLAVE_PSLVERR_EN (adds the pslverr port).

module apb_reg_slave #(
  parameter int NUM_REGS    = 4,
  parameter int WAIT_STATES = 0
) (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] paddr,
  input  logic [7:0] pwdata,
  output logic       pready,
  output logic [7:0] prdata
`ifdef APB_SLAVE_PSLVERR_EN
  ,
  output logic       pslverr
`endif
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    addr_q;
  logic          wr_q;
  logic [3:0]    cnt_q;
  logic          pready_q, pready_d;
  logic [7:0]    prdata_q, prdata_d;
  logic [7:0]    regs_q [NUM_REGS];

  logic          setup;
  logic [7:0]    acc_addr;
  logic          acc_wr;
  logic          in_range;
  logic [AW-1:0] idx;
  logic [7:0]    rd_val;
  logic          commit;
  logic          enter_ready;

  assign setup = (state_q == S_IDLE) && psel && !penable;

  // With zero wait states READY is entered on the setup edge itself, before
  // addr_q/wr_q are loaded, so the live bus values are used in IDLE.
  assign acc_addr = (state_q == S_IDLE) ? paddr  : addr_q;
  assign acc_wr   = (state_q == S_IDLE) ? pwrite : wr_q;

  assign in_range = ({1'b0, acc_addr} < 9'(NUM_REGS));
  assign idx      = acc_addr[AW-1:0];
  assign rd_val   = in_range ? regs_q[idx] : 8'h00;

  // Outside IDLE acc_addr equals addr_q, so in_range/idx refer to the latched address.
  assign commit = (state_q == S_READY) && psel && penable && pready_q && wr_q && in_range;

  // State register
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (setup) state_d = (WAIT_STATES == 0) ? S_READY : S_WAIT;
      end
      S_WAIT: begin
        if (!psel)              state_d = S_IDLE;
        else if (cnt_q <= 4'd1) state_d = S_READY;
      end
      S_READY: begin
        if (!psel || penable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output next-state: outputs are registered and change on the edge entering READY.
  assign enter_ready = (state_d == S_READY) && (state_q != S_READY);

  always_comb begin
    pready_d = (state_d == S_READY);
    prdata_d = prdata_q;
    if (enter_ready) prdata_d = acc_wr ? 8'h00 : rd_val;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      pready_q <= 1'b0;
      prdata_q <= 8'h00;
    end else begin
      pready_q <= pready_d;
      prdata_q <= prdata_d;
    end
  end

  assign pready = pready_q;
  assign prdata = prdata_q;

`ifdef APB_SLAVE_PSLVERR_EN
  logic pslverr_q, pslverr_d;

  // The address is stable for the whole READY stay, so this holds with pready.
  assign pslverr_d = (state_d == S_READY) && !in_range;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) pslverr_q <= 1'b0;
    else          pslverr_q <= pslverr_d;
  end

  assign pslverr = pslverr_q;
`endif

  // Transfer attributes and wait counter; the counter reloads only in setup and stops at zero.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      addr_q <= 8'h00;
      wr_q   <= 1'b0;
      cnt_q  <= 4'd0;
    end else if (setup) begin
      addr_q <= paddr;
      wr_q   <= pwrite;
      cnt_q  <= 4'(WAIT_STATES);
    end else if (state_q == S_WAIT && cnt_q != 4'd0) begin
      cnt_q  <= cnt_q - 4'd1;
    end
  end

  // Register file
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn)                      regs_q[g] <= 8'h00;
      else if (commit && idx == AW'(g))  regs_q[g] <= pwdata;
    end
  end

endmodule
